// File: rtl/pmod_joystick_spi_responder.sv
// pmod_joystick_spi_responder
//   Device-side emulation of the PmodJSTK SPI joystick for the loopback harness.
//   A joystick master reads a 5-byte frame of X, Y and button data from this block
//   and writes an LED command byte to it. The frame is built from x_in/y_in/btn_in
//   at the moment chip select goes low. All SPI pins are oversampled in the clk
//   domain, and nothing in the block is clocked by sclk.
//
// Ports
//   clk, reset        system clock (>= 8x sclk); asynchronous active-high reset
//   cs_n, sclk, mosi  SPI from the master (mode 0, sclk idles low)
//   miso, miso_oe     SPI data to the master, and the pad tri-state enable
//   x_in, y_in        10-bit joystick position reported in the frame
//   btn_in            {btn2, btn1, joystick_btn}
//   led               last valid LED command {led2, led1}
//   frame_done        1-clk pulse when a complete 40-bit frame is closed by cs_n
//   frame_err         1-clk pulse when cs_n closes a frame after 1..39 bits
module pmod_joystick_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BYTES = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs_n,
   input  logic       sclk,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_oe,
   input  logic [9:0] x_in,
   input  logic [9:0] y_in,
   input  logic [2:0] btn_in,
   output logic [1:0] led,
   output logic       frame_done,
   output logic       frame_err
);

   localparam int FRAME_BITS = FRAME_BYTES * 8;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

   state_t                  state;
   logic [SYNC_STAGES-1:0]  cs_sync;
   logic [SYNC_STAGES-1:0]  sclk_sync;
   logic [SYNC_STAGES-1:0]  mosi_sync;
   logic                    cs_prev;
   logic                    sclk_prev;
   logic [5:0]              bit_cnt;
   logic [FRAME_BITS-1:0]   tx_sr;
   logic [7:0]              rx_sr;

   logic                    cs_s;
   logic                    sclk_s;
   logic                    mosi_s;
   logic                    cs_fall;
   logic                    cs_rise;
   logic                    sclk_rise;
   logic                    sclk_fall;
   logic [7:0]              rx_next;
   logic [FRAME_BITS-1:0]   tx_image;

   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_fall   = cs_prev & ~cs_s;
   assign cs_rise   = ~cs_prev & cs_s;
   assign sclk_rise = ~sclk_prev & sclk_s;
   assign sclk_fall = sclk_prev & ~sclk_s;
   assign rx_next   = {rx_sr[6:0], mosi_s};

   // Frame layout, first byte in the MSBs so the image simply shifts left.
   assign tx_image = {x_in[7:0], 6'b0, x_in[9:8],
                      y_in[7:0], 6'b0, y_in[9:8],
                      5'b0, btn_in};

   // Input synchronizers plus one history flop each for edge detection.
   // cs_n resets to its deselected level so reset release never fakes a falling edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_prev   <= 1'b1;
         sclk_prev <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_prev   <= cs_s;
         sclk_prev <= sclk_s;
      end
   end

   // Frame FSM; all outputs are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         led        <= 2'b00;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         bit_cnt    <= '0;
         tx_sr      <= '0;
         rx_sr      <= '0;
      end else begin
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         case (state)
            IDLE: begin
               miso    <= 1'b0;
               miso_oe <= 1'b0;
               if (cs_fall) begin
                  tx_sr   <= tx_image;
                  miso    <= tx_image[FRAME_BITS-1];
                  miso_oe <= 1'b1;
                  bit_cnt <= '0;
                  rx_sr   <= '0;
                  state   <= SHIFT;
               end
            end

            SHIFT: begin
               // Deselect wins over any sclk edge seen on the same sample.
               if (cs_rise) begin
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
                  state   <= IDLE;
                  if (bit_cnt == 6'(FRAME_BITS))
                     frame_done <= 1'b1;
                  else if (bit_cnt != '0)
                     frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  rx_sr   <= rx_next;
                  bit_cnt <= bit_cnt + 6'd1;
                  // The command byte is complete on the 8th rising edge.
                  if (bit_cnt == 6'd7 && rx_next[7:2] == 6'b100000)
                     led <= rx_next[1:0];
               end else if (sclk_fall && bit_cnt != '0) begin
                  if (bit_cnt == 6'(FRAME_BITS)) begin
                     miso  <= 1'b0;
                     state <= DRAIN;
                  end else begin
                     miso  <= tx_sr[FRAME_BITS-2];
                     tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
                  end
               end
            end

            DRAIN: begin
               miso <= 1'b0;
               if (cs_rise) begin
                  miso_oe    <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end

            default: begin
               miso    <= 1'b0;
               miso_oe <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pmod_joystick_spi_responder.sv
// Testbench for pmod_joystick_spi_responder: a mode-0 SPI master at 1 MHz drives
// frames from a vector table; expected miso bytes go into a scoreboard queue when a
// frame starts and are popped as the master completes each byte.
module tb_pmod_joystick_spi_responder;

   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 500;  // half sclk period in ns

   logic       clk = 1'b0;
   logic       reset;
   logic       cs_n;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [9:0] x_in;
   logic [9:0] y_in;
   logic [2:0] btn_in;
   logic [1:0] led;
   logic       frame_done;
   logic       frame_err;

   pmod_joystick_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BYTES(5)) dut (
      .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
      .led(led), .frame_done(frame_done), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt  = 0;
   logic [7:0] exp_q[$];

   always @(negedge clk) begin
      if (frame_done) done_cnt++;
      if (frame_err)  err_cnt++;
   end

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [2:0] btn;
      logic [7:0] cmd;
      int         nbits;
      logic [1:0] exp_led;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_byte(input logic [9:0] x, input logic [9:0] y,
                                             input logic [2:0] btn, input int idx);
      case (idx)
         0:       return x[7:0];
         1:       return {6'b0, x[9:8]};
         2:       return y[7:0];
         3:       return {6'b0, y[9:8]};
         4:       return {5'b0, btn};
         default: return 8'h00;
      endcase
   endfunction

   task automatic push_frame(input logic [9:0] x, input logic [9:0] y,
                             input logic [2:0] btn, input int nbits);
      for (int b = 0; b < nbits / 8; b++) exp_q.push_back(frame_byte(x, y, btn, b));
   endtask

   // One cs_n window of nbits sclk cycles; x_in switches to chg_x after chg_at cycles.
   task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int chg_at,
                            input logic [9:0] chg_x, input string tag);
      logic [7:0] rx;
      rx   = 8'h00;
      cs_n = 1'b0;
      #HALF;
      check({tag, " oe_in_frame"}, 32'(miso_oe), 32'd1);
      for (int i = 0; i < nbits; i++) begin
         if (i == chg_at) x_in = chg_x;
         mosi = (i < 8) ? cmd[7-i] : 1'b0;
         #HALF;
         rx   = {rx[6:0], miso};
         sclk = 1'b1;
         if (i % 8 == 7) begin
            if (exp_q.size() == 0)
               check({tag, " scoreboard_underflow"}, 32'd1, 32'd0);
            else
               check($sformatf("%s byte%0d", tag, i / 8), 32'(rx), 32'(exp_q.pop_front()));
         end
         #HALF;
         sclk = 1'b0;
      end
      mosi = 1'b0;
      #HALF;
      cs_n = 1'b1;
      repeat (SYNC_STAGES + 1) @(posedge clk);
      #1;
      check({tag, " oe_after_cs"}, 32'(miso_oe), 32'd0);
      #2000;
   endtask

   task automatic run_frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] btn,
                            input logic [7:0] cmd, input int nbits, input logic [1:0] exp_led,
                            input int exp_done, input int exp_err, input string tag);
      int d0, e0;
      x_in = x; y_in = y; btn_in = btn;
      push_frame(x, y, btn, nbits);
      d0 = done_cnt;
      e0 = err_cnt;
      spi_frame(cmd, nbits, -1, x, tag);
      check({tag, " led"}, 32'(led), 32'(exp_led));
      check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(exp_done));
      check({tag, " err_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
      check({tag, " scoreboard_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int d0, e0;
      vecs[0] = '{10'h2A5, 10'h1F0, 3'b101, 8'h83, 40, 2'b11, 1, 0};  // basic read, led 11
      vecs[1] = '{10'h2A5, 10'h1F0, 3'b101, 8'h41, 40, 2'b11, 1, 0};  // bad header, led kept
      vecs[2] = '{10'h155, 10'h0AA, 3'b010, 8'h82, 40, 2'b10, 1, 0};  // led 10
      vecs[3] = '{10'h000, 10'h3FF, 3'b111, 8'h00, 17, 2'b10, 0, 1};  // early deselect
      vecs[4] = '{10'h3FF, 10'h000, 3'b111, 8'h81, 40, 2'b01, 1, 0};  // after error, led 01
      vecs[5] = '{10'h123, 10'h2CD, 3'b010, 8'h80, 48, 2'b00, 1, 0};  // 48 clocks, tail zeros

      reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      x_in = '0; y_in = '0; btn_in = '0;
      repeat (4) @(posedge clk);
      #1;
      check("reset miso", 32'(miso), 32'd0);
      check("reset miso_oe", 32'(miso_oe), 32'd0);
      check("reset led", 32'(led), 32'd0);
      check("reset frame_done", 32'(frame_done), 32'd0);
      check("reset frame_err", 32'(frame_err), 32'd0);
      reset = 1'b0;
      #1000;

      for (int v = 0; v < 6; v++)
         run_frame(vecs[v].x, vecs[v].y, vecs[v].btn, vecs[v].cmd, vecs[v].nbits,
                   vecs[v].exp_led, vecs[v].exp_done, vecs[v].exp_err, $sformatf("vec%0d", v));

      // x_in changes after 3 sclk cycles: frame keeps the snapshot, next frame sees the new value.
      x_in = 10'h000; y_in = 10'h000; btn_in = 3'b000;
      push_frame(10'h000, 10'h000, 3'b000, 40);
      spi_frame(8'h00, 40, 3, 10'h3FF, "xchg_first");
      check("xchg_first scoreboard_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      run_frame(10'h3FF, 10'h000, 3'b000, 8'h00, 40, 2'b00, 1, 0, "xchg_second");

      // Reset at bit 20 of a frame with led=10.
      run_frame(10'h001, 10'h002, 3'b001, 8'h82, 40, 2'b10, 1, 0, "pre_reset");
      x_in = 10'h2A5; y_in = 10'h1F0; btn_in = 3'b101;
      cs_n = 1'b0;
      #HALF;
      for (int i = 0; i < 20; i++) begin
         mosi = 1'b0;
         #HALF; sclk = 1'b1;
         #HALF; sclk = 1'b0;
      end
      #250;
      reset = 1'b1;
      #100;
      check("midreset miso", 32'(miso), 32'd0);
      check("midreset miso_oe", 32'(miso_oe), 32'd0);
      check("midreset led", 32'(led), 32'd0);
      cs_n = 1'b1;
      #100;
      reset = 1'b0;
      d0 = done_cnt;
      e0 = err_cnt;
      #2000;
      check("postreset no_done", 32'(done_cnt - d0), 32'd0);
      check("postreset no_err", 32'(err_cnt - e0), 32'd0);
      run_frame(10'h2A5, 10'h1F0, 3'b101, 8'h83, 40, 2'b11, 1, 0, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
